// File: rtl/ascon_init_loader.sv
// Ascon-128 initialization front-end: loads K/N words, owns the 320-bit state
// register across the permutation rounds, applies the final key XOR, hands off.
//
// state  | meaning
// LOAD   | accept eight key/nonce words, MSW first
// START  | one-cycle start pulse to the permutation stage
// WAIT   | register each round result until finished or timeout
// KEYADD | x3 ^= K_hi, x4 ^= K_lo
// DONE   | present initialized state until downstream accepts
module ascon_init_loader #(
  parameter logic [63:0] IV             = 64'h80400c0600000000,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clear_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [31:0]  in_data_i,
  output logic         perm_start_o,
  output logic [319:0] perm_state_o,
  input  logic [319:0] perm_state_i,
  input  logic         perm_update_i,
  input  logic         perm_finished_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [319:0] out_state_o,
  output logic         busy_o,
  output logic         error_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_KEYADD = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     word_cnt_q, word_cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [127:0]   key_q, key_d;
  logic [319:0]   st_q, st_d;

  logic accept;
  logic tmo_hit;

  assign accept  = (state_q == S_LOAD) && in_valid_i && !clear_i;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_LOAD;
      word_cnt_q <= '0;
      tmo_q      <= '0;
      key_q      <= '0;
      st_q       <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      tmo_q      <= tmo_d;
      key_q      <= key_d;
      st_q       <= st_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:   if (accept && word_cnt_q == 3'd7) state_d = S_START;
      S_START:  state_d = S_WAIT;
      S_WAIT: begin
        if (perm_finished_i)  state_d = S_KEYADD;
        else if (tmo_hit)     state_d = S_LOAD;
      end
      S_KEYADD: state_d = S_DONE;
      S_DONE:   if (out_ready_i) state_d = S_LOAD;
      default:  state_d = S_LOAD;
    endcase
    if (clear_i) state_d = S_LOAD;
  end

  // Words shift in MSW-first, so after 4 (resp. 8) words the first one sits on top.
  always_comb begin
    word_cnt_d = word_cnt_q;
    tmo_d      = tmo_q;
    key_d      = key_q;
    st_d       = st_q;
    unique case (state_q)
      S_LOAD: begin
        if (accept) begin
          word_cnt_d       = word_cnt_q + 3'd1;
          if (!word_cnt_q[2]) key_d = {key_q[95:0], in_data_i};
          st_d[319:256]    = IV;
          st_d[255:0]      = {st_q[223:0], in_data_i};
        end
      end
      S_START: tmo_d = '0;
      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (!perm_finished_i) begin
          if (tmo_hit)            st_d = '0;
          else if (perm_update_i) st_d = perm_state_i;
        end
      end
      S_KEYADD: begin
        st_d[127:64] = st_q[127:64] ^ key_q[127:64];
        st_d[63:0]   = st_q[63:0]   ^ key_q[63:0];
      end
      default: ;
    endcase
    if (clear_i) word_cnt_d = '0;
  end

  always_comb begin
    in_ready_o   = (state_q == S_LOAD);
    perm_start_o = (state_q == S_START) && !clear_i;
    out_valid_o  = (state_q == S_DONE);
    busy_o       = (state_q == S_START) || (state_q == S_WAIT);
    error_o      = (state_q == S_WAIT) && tmo_hit && !perm_finished_i && !clear_i;
    perm_state_o = st_q;
    out_state_o  = st_q;
  end

endmodule

// File: tb/tb_ascon_init_loader.sv
// Bench for ascon_init_loader: a behavioural Ascon permutation responder plus
// directed runs with random keys/nonces compared against a reference model.
module tb_ascon_init_loader;

  localparam logic [63:0] IV = 64'h80400c0600000000;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         clear_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [31:0]  in_data_i;
  logic         perm_start_o;
  logic [319:0] perm_state_o;
  logic [319:0] perm_state_i = '0;
  logic         perm_update_i = 1'b0;
  logic         perm_finished_i = 1'b0;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [319:0] out_state_o;
  logic         busy_o;
  logic         error_o;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int pcnt   = 0;
  int pmode  = 0;   // 0 real Ascon rounds, 1 identity, 2 never finishes

  always #5 clk_i = ~clk_i;

  ascon_init_loader #(.IV(IV), .TIMEOUT_CYCLES(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clear_i(clear_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .perm_start_o(perm_start_o), .perm_state_o(perm_state_o),
    .perm_state_i(perm_state_i), .perm_update_i(perm_update_i),
    .perm_finished_i(perm_finished_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_state_o(out_state_o),
    .busy_o(busy_o), .error_o(error_o)
  );

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] asc_round(input logic [319:0] s, input int r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ 64'(240 - 15 * r);
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] ref_init(input logic [127:0] k, input logic [127:0] n,
                                            input int mode);
    logic [319:0] s;
    s = {IV, k, n};
    if (mode == 0)
      for (int r = 0; r < 12; r++) s = asc_round(s, r);
    return s ^ {192'b0, k};
  endfunction

  // Permutation responder: idle cycle after start, 12 round updates, finished pulse.
  always @(negedge clk_i) begin
    perm_update_i   = 1'b0;
    perm_finished_i = 1'b0;
    if (!rst_n_i) pcnt = 0;
    else if (perm_start_o) begin
      pcnt = 1;
      starts++;
    end else if (pcnt == 1) pcnt = 2;
    else if (pcnt >= 2 && pcnt <= 13) begin
      perm_update_i = 1'b1;
      perm_state_i  = (pmode == 1) ? perm_state_o : asc_round(perm_state_o, pcnt - 2);
      pcnt++;
    end else if (pcnt == 14) begin
      perm_finished_i = (pmode != 2);
      pcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_words(input logic [127:0] k, input logic [127:0] n,
                            input int nwords, input bit gaps);
    logic [255:0] w;
    w = {k, n};
    for (int i = 0; i < nwords; i++) begin
      if (gaps && $urandom_range(1, 0) == 1) begin
        in_valid_i = 1'b0;
        in_data_i  = $urandom;
        @(negedge clk_i);
      end
      in_valid_i = 1'b1;
      in_data_i  = w[255 - 32 * i -: 32];
      if (i == 0) chk("load_ready", 320'(in_ready_o), 320'(1));
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    in_data_i  = $urandom;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
  endtask

  task automatic full_run(input string tag, input logic [127:0] k, input logic [127:0] n,
                          input bit gaps, input int mode);
    int lat, s0;
    logic [319:0] exp;
    pmode = mode;
    s0 = starts;
    exp = ref_init(k, n, mode);
    load_words(k, n, 8, gaps);
    wait_valid(lat);
    chk({tag, "_latency"}, 320'(lat), 320'(16));
    chk({tag, "_starts"}, 320'(starts - s0), 320'(1));
    chk({tag, "_state"}, out_state_o, exp);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    chk({tag, "_reload"}, 320'({in_ready_o, out_valid_o}), 320'(2'b10));
  endtask

  logic [127:0] k0, ka, na;
  logic [319:0] exp;
  bit           stable, seen_valid;
  int           lat, errs, err_at;

  initial begin
    rst_n_i = 1'b0; clear_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", 320'(in_ready_o), 320'(1));
    chk("rst_outs", 320'({perm_start_o, out_valid_o, busy_o, error_o}), 320'(0));
    chk("rst_state", perm_state_o, 320'(0));
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Nominal run with the reference key/nonce, then a 10-cycle output stall.
    k0 = 128'h000102030405060708090a0b0c0d0e0f;
    pmode = 0;
    exp = ref_init(k0, k0, 0);
    load_words(k0, k0, 8, 1'b0);
    wait_valid(lat);
    chk("nom_latency", 320'(lat), 320'(16));
    chk("nom_state", out_state_o, exp);
    chk("nom_perm_state", perm_state_o, exp);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk_i);
      if (out_state_o !== exp || out_valid_o !== 1'b1) stable = 1'b0;
    end
    chk("stall_stable", 320'(stable), 320'(1));
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    chk("nom_reload", 320'({in_ready_o, out_valid_o}), 320'(2'b10));

    // Identity permutation, random key/nonce, input gaps.
    ka = {$urandom, $urandom, $urandom, $urandom};
    na = {$urandom, $urandom, $urandom, $urandom};
    full_run("ident", ka, na, 1'b1, 1);

    // Timeout: finished never arrives.
    pmode = 2;
    ka = {$urandom, $urandom, $urandom, $urandom};
    load_words(ka, ka ^ 128'h5a, 8, 1'b0);
    errs = 0; err_at = 0; seen_valid = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk_i);
      if (error_o) begin errs++; err_at = i; end
      if (out_valid_o) seen_valid = 1'b1;
    end
    chk("tmo_pulses", 320'(errs), 320'(1));
    chk("tmo_cycle", 320'(err_at), 320'(32));
    chk("tmo_ready", 320'(in_ready_o), 320'(1));
    chk("tmo_no_valid", 320'(seen_valid), 320'(0));
    chk("tmo_zeroed", perm_state_o, 320'(0));

    // Clear after word 5, then a full fresh load.
    pmode = 0;
    load_words(128'hdeadbeef, 128'hcafef00d, 6, 1'b0);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("clr_load_ready", 320'(in_ready_o), 320'(1));
    full_run("clr1", {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);

    // Clear in WAIT, then another fresh run.
    load_words({$urandom, $urandom, $urandom, $urandom}, 128'h1, 8, 1'b0);
    repeat (4) @(negedge clk_i);
    chk("clr_wait_busy", 320'(busy_o), 320'(1));
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("clr_wait_after", 320'({in_ready_o, busy_o, out_valid_o}), 320'(3'b100));
    full_run("clr2", {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0);

    // Asynchronous reset in WAIT.
    load_words({$urandom, $urandom, $urandom, $urandom}, 128'h2, 8, 1'b0);
    repeat (5) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    chk("arst_outs", 320'({in_ready_o, perm_start_o, out_valid_o, busy_o, error_o}), 320'(5'b10000));
    chk("arst_state", perm_state_o, 320'(0));
    @(negedge clk_i);
    chk("arst_hold", 320'({in_ready_o, busy_o, out_valid_o}), 320'(3'b100));
    rst_n_i = 1'b1;
    @(negedge clk_i);
    full_run("post_rst", {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
